// File: rtl/dmem_router.sv
// Data-memory request router: forwards one CPU request to one of four
// targets by the top two address bits and returns a registered completion.
module dmem_router #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_ack,
  output logic             cpu_err,
  output logic [3:0]       t_req,
  output logic             t_we,
  output logic [WIDTH-1:0] t_addr,
  output logic [WIDTH-1:0] t_wdata,
  input  logic [WIDTH-1:0] t_rdata0,
  input  logic [WIDTH-1:0] t_rdata1,
  input  logic [WIDTH-1:0] t_rdata2,
  input  logic [WIDTH-1:0] t_rdata3,
  input  logic [3:0]       t_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [1:0]       sel;
  logic [CW-1:0]    cnt;
  logic             err;
  logic             hit;
  logic             tmo;
  logic [WIDTH-1:0] rsel;

  assign hit = t_ack[sel];
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    rsel = '0;
    unique case (sel)
      2'd0: rsel = t_rdata0;
      2'd1: rsel = t_rdata1;
      2'd2: rsel = t_rdata2;
      2'd3: rsel = t_rdata3;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (cpu_req) state_d = BUSY;
      BUSY:    if (hit || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Completion flags are raised one edge after DONE entry so every
  // output stays a plain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      t_req     <= '0;
      t_we      <= 1'b0;
      t_addr    <= '0;
      t_wdata   <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            sel     <= cpu_addr[WIDTH-1 -: 2];
            t_req   <= 4'b0001 << cpu_addr[WIDTH-1 -: 2];
            t_we    <= cpu_we;
            t_addr  <= cpu_addr;
            t_wdata <= cpu_wdata;
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (hit) begin
            t_req     <= '0;
            cpu_rdata <= t_we ? '0 : rsel;
            err       <= 1'b0;
          end else if (tmo) begin
            t_req     <= '0;
            cpu_rdata <= '0;
            err       <= 1'b1;
          end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cpu_ack <= 1'b1;
          cpu_err <= err;
        end
        default: t_req <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_router.sv
// Bench for dmem_router: directed and random transactions checked
// against a latency/outcome model derived from the ack schedule.
module tb_dmem_router;

  localparam int W  = 32;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req;
  logic         cpu_we;
  logic [W-1:0] cpu_addr;
  logic [W-1:0] cpu_wdata;
  logic [W-1:0] cpu_rdata;
  logic         cpu_ack;
  logic         cpu_err;
  logic [3:0]   t_req;
  logic         t_we;
  logic [W-1:0] t_addr;
  logic [W-1:0] t_wdata;
  logic [W-1:0] trd [4];
  logic [3:0]   t_ack;

  int errors = 0;
  int checks = 0;

  dmem_router #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .t_req     (t_req),
    .t_we      (t_we),
    .t_addr    (t_addr),
    .t_wdata   (t_wdata),
    .t_rdata0  (trd[0]),
    .t_rdata1  (trd[1]),
    .t_rdata2  (trd[2]),
    .t_rdata3  (trd[3]),
    .t_ack     (t_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // noise: 0 = other acks low, 1 = other acks random, 2 = other acks high
  task automatic drive_acks(input int sel, input int noise, input logic a);
    logic [3:0] v;
    v = (noise == 2) ? 4'hf : (noise == 1) ? 4'($urandom) : 4'h0;
    v[sel] = a;
    t_ack = v;
    for (int i = 0; i < 4; i++)
      if (i != sel) trd[i] = $urandom;
  endtask

  // One request. Target acks from BUSY cycle 'delay' on (0 = at the first
  // BUSY edge). Completion happens at BUSY cycle k, ack wins on cycle TO-1.
  task automatic txn(input logic we, input logic [W-1:0] addr,
                     input logic [W-1:0] wdata, input logic [W-1:0] rd,
                     input int delay, input int noise, input bit hold);
    int sel;
    int k;
    bit tmo;
    logic [3:0] oh;
    sel = int'(addr[W-1:W-2]);
    tmo = delay > TO - 1;
    k = tmo ? TO - 1 : delay;
    oh = 4'b0001 << sel;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wdata;
    trd[sel] = rd;
    drive_acks(sel, noise, 1'b0);
    @(negedge clk);
    for (int j = 0; j <= k + 2; j++) begin
      chk("t_req", W'(t_req), W'(j <= k ? oh : 4'h0));
      if (j <= k) begin
        chk("t_we", W'(t_we), W'(we));
        chk("t_addr", t_addr, addr);
        chk("t_wdata", t_wdata, wdata);
      end
      chk("cpu_ack", W'(cpu_ack), W'(j == k + 2));
      if (j == k + 2) begin
        chk("cpu_rdata", cpu_rdata, (tmo || we) ? '0 : rd);
        chk("cpu_err", W'(cpu_err), W'(tmo));
      end else begin
        chk("cpu_err_idle", W'(cpu_err), '0);
      end
      if (j < k + 2) begin
        cpu_req = hold;
        cpu_we = 1'($urandom);
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
        drive_acks(sel, noise, j >= delay);
        @(negedge clk);
      end
    end
    if (!hold) begin
      cpu_req = 1'b0;
      t_ack = 4'h0;
      @(negedge clk);
      chk("ack_pulse", W'(cpu_ack), '0);
      chk("t_req_idle", W'(t_req), '0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    t_ack = 4'h0;
    for (int i = 0; i < 4; i++) trd[i] = '0;
    #12;
    chk("rst_t_req", W'(t_req), '0);
    chk("rst_ack", W'(cpu_ack), '0);
    chk("rst_rdata", cpu_rdata, '0);
    chk("rst_t_addr", t_addr, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2, 0, 1'b0);
    txn(1'b1, 32'h4000_0004, 32'h1234_5678, 32'hAAAA_5555, 0, 0, 1'b0);
    txn(1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 6, 2, 1'b0);
    txn(1'b0, 32'hC000_0040, 32'h0, 32'h7777_1111, 15, 0, 1'b0);
    txn(1'b0, 32'hC000_0044, 32'h0, 32'h7777_2222, 14, 0, 1'b0);

    for (int n = 0; n < 6; n++)
      txn(1'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 4)), 1, n < 5);

    for (int n = 0; n < 20; n++)
      txn(1'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 17)), 1, 1'b0);

    // Reset in the middle of a transaction with no ack pending.
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 32'h4000_0100;
    cpu_wdata = 32'h5555_AAAA;
    t_ack = 4'h0;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("pre_rst_t_req", W'(t_req), W'(4'b0010));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_t_req", W'(t_req), '0);
    chk("mid_rst_ack", W'(cpu_ack), '0);
    chk("mid_rst_t_addr", t_addr, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("post_rst_ack", W'(cpu_ack), '0);
      chk("post_rst_t_req", W'(t_req), '0);
    end
    chk("post_rst_t_we", W'(t_we), '0);
    chk("post_rst_t_wdata", t_wdata, '0);
    chk("post_rst_rdata", cpu_rdata, '0);
    chk("post_rst_err", W'(cpu_err), '0);

    txn(1'b0, 32'h8000_0200, 32'h0, 32'hCAFE_0001, 1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
